mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- MEM-stage data-memory sequencer for the 5-stage RV32I pipeline. Sits between the EX/MEM register and the data-cache port.
- Issues one load or store per EX/MEM occupancy, holds it stable until the cache responds, and stalls the pipeline meanwhile.
- Produces the write byte-enables and lane-shifted store data.
- Returns the raw load word consumed by the lw/lb/lbu/lh/lhu legs of regfilemux in WB.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, not otherwise supported.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  EX/MEM holds a valid instruction.
- req_load  in  1  instruction is a load.
- req_store  in  1  instruction is a store.
- funct3  in  3  RV32I load/store funct3.
- req_addr  in  32  effective address from EX/MEM alu_out.
- req_wdata  in  32  store data after mem_forwardmux2.
- pipe_advance  in  1  hazard unit moves all pipeline registers this cycle.
- dmem_read  out  1  cache read request.
- dmem_write  out  1  cache write request.
- dmem_address  out  32  word-aligned address, bits [1:0] = 0.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_mbe  out  4  byte enables.
- dmem_rdata  in  32  cache read data.
- dmem_resp  in  1  cache response, one-cycle pulse.
- mem_rdata  out  32  raw load word to MEM/WB.
- mem_stall  out  1  freeze upstream pipeline registers.

Behaviour:
- Memory op: mem_op = req_valid & (req_load | req_store). If both load and store are set, the load wins.
- Reset: state = IDLE; all latched registers = 0; dmem_read, dmem_write, mem_stall = 0; mem_rdata = 0.
- States: IDLE, BUSY, DONE.

IDLE:
- If mem_op, drive the request combinationally from the inputs and capture address, mbe, wdata and rw into request registers.
- If dmem_resp in the same cycle (zero-wait cache): go to DONE, or to IDLE if pipe_advance.
- Otherwise go to BUSY.

BUSY:
- Drive the request from the captured registers only; request stays stable regardless of input changes.
- On dmem_resp: go to DONE, or to IDLE if pipe_advance in the same cycle.

DONE:
- No request asserted. Hold the latched data.
- Go to IDLE on pipe_advance.
- The same EX/MEM occupancy is never reissued.

Stall and read data:
- mem_stall = mem_op & ~dmem_resp & (state != DONE), combinational.
- mem_rdata = dmem_resp ? dmem_rdata : rdata_q, where rdata_q is latched on every dmem_resp for loads.
- Store responses do not update rdata_q.

Address and byte enables:
- dmem_address = {addr[31:2], 2'b00}.
- Loads: mbe = 4'b1111.
- SB: mbe = 4'b0001 << addr[1:0]; wdata = req_wdata[7:0] << 8*addr[1:0].
- SH: mbe = 4'b0011 << 2*addr[1]; wdata = req_wdata[15:0] << 16*addr[1].
- SW: mbe = 4'b1111; wdata = req_wdata.
- Other funct3 values: treated as SW.

Other rules:
- No request when req_valid = 0 (bubble). In that case mem_stall = 0 and the state stays IDLE.
- pipe_advance in IDLE or BUSY without a response is a hazard-unit error. It is ignored: the state is held.
- Reset asserted mid-BUSY: request drops immediately (async). The in-flight transaction is abandoned; the cache is reset together with this block.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign_err (1 bit).
  - Misaligned means: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
  - On a misaligned op in IDLE: no dmem_read/dmem_write, mem_stall = 0, misalign_err = 1 while the op is held, mem_rdata = 0.
- When not defined:
  - No misalign_err port.
  - The access proceeds with the address truncated as above; SH at addr[1:0] = 3 uses mbe 4'b1100.

Test Plan:
- LW at 0x100, cache resp 3 cycles later with 0xDEADBEEF, then pipe_advance: dmem_read high for 4 cycles at 0x100 with mbe 1111; mem_stall high for 3 cycles; mem_rdata = 0xDEADBEEF on the resp cycle; exactly one request.
- SB at 0x203 with req_wdata 0x000000A5: dmem_write, address 0x200, mbe 1000, wdata 0xA5000000.
- SH at 0x302 with 0x1234: mbe 1100, wdata 0x12340000. Change req_wdata during BUSY: dmem_wdata is unchanged.
- Zero-wait resp in IDLE with pipe_advance: mem_stall never asserts; the next LW at 0x104 issues the following cycle.
- Resp without pipe_advance (other stage stalled): state DONE, no reissue for 5 cycles, mem_rdata held; advance returns the state to IDLE.
- Assert rst mid-BUSY: dmem_read and mem_stall = 0 asynchronously. With MEM_MISALIGN_TRAP_EN, LW at 0x101 gives misalign_err = 1 and no request.

Source files
------------

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Bundles every signal of the MEM-stage sequencer except clk/rst.
//   Pipeline side : req_valid, req_load, req_store, funct3, req_addr,
//                   req_wdata, pipe_advance (in);  mem_rdata, mem_stall (out)
//   Cache side    : dmem_read, dmem_write, dmem_address, dmem_wdata,
//                   dmem_mbe (out);  dmem_rdata, dmem_resp (in)
//   Optional      : misalign_err (out), present only when the macro
//                   MEM_MISALIGN_TRAP_EN is defined.
// Modports:
//   slave  - the sequencer itself (mem_stage_ctrl).
//   master - whatever surrounds it: EX/MEM register, hazard unit and cache.
// -----------------------------------------------------------------------------
interface mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_load;
  logic              req_store;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              pipe_advance;

  logic              dmem_read;
  logic              dmem_write;
  logic [ADDR_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_wdata;
  logic [3:0]        dmem_mbe;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_resp;

  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              misalign_err;
`endif

  modport master (
`ifdef MEM_MISALIGN_TRAP_EN
    input  misalign_err,
`endif
    output req_valid, req_load, req_store, funct3, req_addr, req_wdata,
    output pipe_advance, dmem_rdata, dmem_resp,
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    input  mem_rdata, mem_stall
  );

  modport slave (
`ifdef MEM_MISALIGN_TRAP_EN
    output misalign_err,
`endif
    input  req_valid, req_load, req_store, funct3, req_addr, req_wdata,
    input  pipe_advance, dmem_rdata, dmem_resp,
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    output mem_rdata, mem_stall
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// MEM-stage data-memory sequencer for the 5-stage RV32I pipeline. Issues one
// load or store per EX/MEM occupancy, holds it stable until the cache
// responds, stalls the pipeline meanwhile, builds byte enables and
// lane-shifted store data, and returns the raw load word for WB.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - mem_stage_if.slave (pipeline request, cache port, stall, rdata)
// Optional build macro:
//   MEM_MISALIGN_TRAP_EN - misaligned halfword/word ops raise misalign_err
//   instead of issuing; otherwise the low address bits are truncated.
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // only 32 is supported
) (
  input  logic         clk,
  input  logic         rst,
  mem_stage_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;

  // Captured request, driven to the cache while BUSY
  logic              load_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        mbe_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              mem_op;
  logic              op_load;   // load wins when both load and store are set
  logic              issue;     // new request leaves IDLE this cycle
  logic              req_idle, req_busy, cur_load;
  logic [3:0]        new_mbe;
  logic [DATA_W-1:0] new_wdata;
  logic [ADDR_W-1:0] new_addr;

  assign mem_op   = bus.req_valid & (bus.req_load | bus.req_store);
  assign op_load  = bus.req_load;
  assign new_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};

  // Byte-enable and lane placement. Only SB/SH are special; every other
  // store funct3 behaves as SW, and loads always read the full word.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    new_mbe   = 4'b1111;
    new_wdata = bus.req_wdata;
    if (!op_load) begin
      case (bus.funct3)
        3'b000: begin
          new_mbe   = 4'b0001 << bus.req_addr[1:0];
          new_wdata = {{(DATA_W-8){1'b0}}, bus.req_wdata[7:0]}
                      << {bus.req_addr[1:0], 3'b000};
        end
        3'b001: begin
          new_mbe   = 4'b0011 << {bus.req_addr[1], 1'b0};
          new_wdata = {{(DATA_W-16){1'b0}}, bus.req_wdata[15:0]}
                      << {bus.req_addr[1], 4'b0000};
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic is_byte, is_half, misalign;

  // Access size class follows the same decode as the lane logic above.
  assign is_byte  = op_load ? (bus.funct3[1:0] == 2'b00) : (bus.funct3 == 3'b000);
  assign is_half  = op_load ? (bus.funct3[1:0] == 2'b01) : (bus.funct3 == 3'b001);
  assign misalign = is_half ? bus.req_addr[0]
                            : (!is_byte && (bus.req_addr[1:0] != 2'b00));
  assign issue    = mem_op & ~misalign;

  // Held for as long as the faulting op sits in EX/MEM; nothing is issued.
  assign bus.misalign_err = ~rst & (state_q == S_IDLE) & mem_op & misalign;
`else
  assign issue    = mem_op;
`endif

  assign req_idle = (state_q == S_IDLE) & issue;
  assign req_busy = (state_q == S_BUSY);
  assign cur_load = req_busy ? load_q : op_load;

  // pipe_advance without a response in IDLE/BUSY is a hazard-unit error and
  // is deliberately ignored: the state simply holds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue)
                 state_d = !bus.dmem_resp ? S_BUSY
                         : (bus.pipe_advance ? S_IDLE : S_DONE);
      S_BUSY:  if (bus.dmem_resp)
                 state_d = bus.pipe_advance ? S_IDLE : S_DONE;
      S_DONE:  if (bus.pipe_advance)
                 state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the request and read-data registers are ordinary flops, not a
  // memory array, so they are all cleared by reset like the state.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      load_q  <= 1'b0;
      addr_q  <= '0;
      mbe_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_idle) begin
        load_q  <= op_load;
        addr_q  <= new_addr;
        mbe_q   <= new_mbe;
        wdata_q <= new_wdata;
      end
      // Store responses leave the last load word untouched.
      if (bus.dmem_resp && (req_idle || req_busy) && cur_load)
        rdata_q <= bus.dmem_rdata;
    end
  end

  // IDLE issues straight from the inputs (zero-wait caches complete in one
  // cycle); BUSY replays the captured copy so upstream changes cannot leak.
  // Everything is gated by rst so an in-flight request drops asynchronously.
  assign bus.dmem_read    = ~rst & ((req_idle & op_load)  | (req_busy & load_q));
  assign bus.dmem_write   = ~rst & ((req_idle & ~op_load) | (req_busy & ~load_q));
  assign bus.dmem_address = req_busy ? addr_q  : new_addr;
  assign bus.dmem_mbe     = req_busy ? mbe_q   : new_mbe;
  assign bus.dmem_wdata   = req_busy ? wdata_q : new_wdata;

  assign bus.mem_stall = ~rst & ~bus.dmem_resp & (req_idle | (req_busy & mem_op));

`ifdef MEM_MISALIGN_TRAP_EN
  assign bus.mem_rdata = (rst || bus.misalign_err) ? '0
                       : (bus.dmem_resp ? bus.dmem_rdata : rdata_q);
`else
  assign bus.mem_rdata = rst ? '0 : (bus.dmem_resp ? bus.dmem_rdata : rdata_q);
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Scoreboard bench for mem_stage_ctrl. The driver plays EX/MEM register,
// hazard unit and cache; for every issued op it pushes the expected cache
// transaction. A negedge monitor compares each cycle the DUT requests against
// the queue head, pops it on the response, and tracks the last load word.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mbe;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_stage_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  exp_t        exp_q[$];
  logic [31:0] last_load   = 32'h0;
  int          rd_cycles   = 0;
  int          stall_cycles = 0;
  bit          tb_misalign = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [3:0] m, input logic [31:0] w, input logic [31:0] r);
    exp_t e;
    e.rd = rd; e.wr = wr; e.addr = a; e.mbe = m; e.wdata = w; e.rdata = r;
    return e;
  endfunction

  // Reference model: what the cache should see for one op.
  function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] w, input logic [31:0] r);
    exp_t e;
    int   lane, half;
    lane = int'(a % 4);
    half = int'((a / 2) % 2);
    e = mk(ld, st & ~ld, a - (a % 4), 4'hF, w, r);
    if (!ld) begin
      if (f3 == 3'd0) begin
        e.mbe   = 4'(1 << lane);
        e.wdata = (w & 32'hFF) << (8 * lane);
      end else if (f3 == 3'd1) begin
        e.mbe   = 4'(3 << (2 * half));
        e.wdata = (w & 32'hFFFF) << (16 * half);
      end
    end
    return e;
  endfunction

  // Monitor / scoreboard
  logic req_act;
  exp_t head;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_read",  bus.dmem_read,  0);
      check("rst_write", bus.dmem_write, 0);
      check("rst_stall", bus.mem_stall,  0);
      check("rst_rdata", bus.mem_rdata,  0);
      last_load = 32'h0;
    end else begin
      req_act = bus.dmem_read | bus.dmem_write;
      rd_cycles    += int'(bus.dmem_read);
      stall_cycles += int'(bus.mem_stall);
      check("stall", bus.mem_stall, req_act & ~bus.dmem_resp);
      if (req_act) begin
        if (exp_q.size() == 0) begin
          check("spurious_req", req_act, 0);
        end else begin
          head = exp_q[0];
          check("req_read",  bus.dmem_read,    head.rd);
          check("req_write", bus.dmem_write,   head.wr);
          check("req_addr",  bus.dmem_address, head.addr);
          check("req_mbe",   bus.dmem_mbe,     head.mbe);
          if (head.wr) check("req_wdata", bus.dmem_wdata, head.wdata);
          if (bus.dmem_resp) begin
            check("resp_rdata", bus.mem_rdata, head.rdata);
            if (head.rd) last_load = head.rdata;
            void'(exp_q.pop_front());
          end
        end
      end
      if (!bus.dmem_resp)
        check("held_rdata", bus.mem_rdata, tb_misalign ? 32'h0 : last_load);
`ifdef MEM_MISALIGN_TRAP_EN
      check("misalign_err", bus.misalign_err, tb_misalign);
`endif
    end
  end

  task automatic bubble();
    bus.req_valid    = 1'b0;
    bus.pipe_advance = 1'b0;
    bus.dmem_resp    = 1'b0;
  endtask

  // One EX/MEM occupancy: resp after lat cycles, then hold cycles in DONE
  // before the pipeline advances. scr scrambles inputs while they must be
  // ignored and throws in stray pipe_advance pulses while BUSY.
  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int lat, input int hold, input exp_t e, input bit scr);
    exp_q.push_back(e);
    bus.req_valid    = 1'b1;
    bus.req_load     = ld;
    bus.req_store    = st;
    bus.funct3       = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.dmem_resp    = 1'b0;
    bus.dmem_rdata   = $urandom;
    bus.pipe_advance = scr ? ($urandom_range(0, 3) == 0) : 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      bus.dmem_rdata = $urandom;
      if (scr) begin
        bus.req_wdata    = $urandom;
        bus.req_addr     = $urandom;
        bus.funct3       = 3'($urandom);
        bus.pipe_advance = ($urandom_range(0, 3) == 0);
      end
    end
    bus.dmem_resp    = 1'b1;
    bus.dmem_rdata   = e.rdata;
    bus.pipe_advance = (hold == 0);
    @(posedge clk); #1;
    bus.dmem_resp  = 1'b0;
    bus.dmem_rdata = $urandom;
    if (hold > 0) begin
      bus.pipe_advance = 1'b0;
      for (int i = 0; i < hold; i++) begin
        if (scr) bus.req_wdata = $urandom;
        @(posedge clk); #1;
        bus.dmem_rdata = $urandom;
      end
      bus.pipe_advance = 1'b1;
      @(posedge clk); #1;
    end
    check("queue_drained", exp_q.size(), 0);
    bubble();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rd, base_st;
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] a, w, r;

    bus.req_load = 1'b0; bus.req_store = 1'b0; bus.funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.dmem_rdata = 32'h0;
    bubble();
    #1;
    check("reset_read",  bus.dmem_read, 0);
    check("reset_stall", bus.mem_stall, 0);
    check("reset_rdata", bus.mem_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // LW 0x100, resp after 3 cycles
    base_rd = rd_cycles; base_st = stall_cycles;
    do_op(1, 0, 3'd2, 32'h100, 32'h0, 3, 0, mk(1, 0, 32'h100, 4'hF, 0, 32'hDEADBEEF), 0);
    check("lw_read_cycles",  rd_cycles - base_rd, 4);
    check("lw_stall_cycles", stall_cycles - base_st, 3);

    // SB 0x203
    do_op(0, 1, 3'd0, 32'h203, 32'h000000A5, 1, 0,
          mk(0, 1, 32'h200, 4'b1000, 32'hA5000000, 32'h11112222), 0);

    // SH 0x302 with req_wdata scrambled during BUSY
    do_op(0, 1, 3'd1, 32'h302, 32'h00001234, 3, 0,
          mk(0, 1, 32'h300, 4'b1100, 32'h12340000, 32'h33334444), 1);

    // Zero-wait back-to-back LWs: no stall at all
    base_rd = rd_cycles; base_st = stall_cycles;
    do_op(1, 0, 3'd2, 32'h100, 32'h0, 0, 0, mk(1, 0, 32'h100, 4'hF, 0, 32'hCAFEF00D), 0);
    do_op(1, 0, 3'd2, 32'h104, 32'h0, 0, 0, mk(1, 0, 32'h104, 4'hF, 0, 32'h0BADC0DE), 0);
    check("zw_read_cycles",  rd_cycles - base_rd, 2);
    check("zw_stall_cycles", stall_cycles - base_st, 0);

    // Resp without advance: 5 cycles in DONE, no reissue, data held
    base_rd = rd_cycles;
    do_op(1, 0, 3'd2, 32'h40, 32'h0, 2, 5, mk(1, 0, 32'h40, 4'hF, 0, 32'h13579BDF), 1);
    check("done_read_cycles", rd_cycles - base_rd, 3);

    // Store response must not replace the held load word
    do_op(0, 1, 3'd2, 32'h44, 32'h89ABCDEF, 1, 0,
          mk(0, 1, 32'h44, 4'hF, 32'h89ABCDEF, 32'hFFFF0000), 0);

    // Load and store both set: load wins
    do_op(1, 1, 3'd2, 32'h48, 32'h55555555, 1, 0, mk(1, 0, 32'h48, 4'hF, 0, 32'h2468ACE0), 0);

`ifndef MEM_MISALIGN_TRAP_EN
    // SH at offset 3 truncates to the upper halfword
    do_op(0, 1, 3'd1, 32'h303, 32'h0000BEEF, 1, 0,
          mk(0, 1, 32'h300, 4'b1100, 32'hBEEF0000, 32'h0), 0);
`endif

    // Reset mid-BUSY: request and stall drop asynchronously
    exp_q.push_back(mk(1, 0, 32'h80, 4'hF, 0, 0));
    bus.req_valid = 1'b1; bus.req_load = 1'b1; bus.req_store = 1'b0;
    bus.funct3 = 3'd2; bus.req_addr = 32'h80;
    repeat (2) begin @(posedge clk); #1; end
    check("busy_read_before_rst", bus.dmem_read, 1);
    rst = 1'b1;
    #1;
    check("rst_async_read",  bus.dmem_read, 0);
    check("rst_async_stall", bus.mem_stall, 0);
    void'(exp_q.pop_front());
    bubble();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(1, 0, 3'd4, 32'h87, 32'h0, 1, 0, mk(1, 0, 32'h84, 4'hF, 0, 32'h77778888), 0);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned LW: error flag, no request, no stall
    tb_misalign = 1'b1;
    bus.req_valid = 1'b1; bus.req_load = 1'b1; bus.req_store = 1'b0;
    bus.funct3 = 3'd2; bus.req_addr = 32'h101;
    #1;
    check("misalign_flag", bus.misalign_err, 1);
    check("misalign_no_read", bus.dmem_read, 0);
    repeat (3) begin @(posedge clk); #1; end
    bus.pipe_advance = 1'b1;
    @(posedge clk); #1;
    bubble();
    tb_misalign = 1'b0;
    @(posedge clk); #1;
`endif

    // Randomized traffic with bubbles
    for (int n = 0; n < 300; n++) begin
      int k;
      k  = $urandom_range(0, 7);
      ld = (k < 4);
      st = (k >= 4) || (k == 0);
      f3 = ld ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 3));
      if (ld && f3 >= 3'd3) f3 = f3 + 3'd1;
      a  = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      a[1:0] = 2'b00;
`endif
      w  = $urandom;
      r  = $urandom;
      do_op(ld, st, f3, a, w, $urandom_range(0, 4),
            ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
            model(ld, st, f3, a, w, r), 1);
      if ($urandom_range(0, 2) == 0) begin
        bus.req_load = 1'($urandom); bus.req_store = 1'($urandom);
        bus.pipe_advance = 1'($urandom);
        @(posedge clk); #1;
        bubble();
      end
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
